// File: rtl/result_pipe_ep_if.sv
// Issue, flush, unit-result and result-staging bundle for the even-pipe result pipeline.
// The master side issues instructions and presents unit results; the slave side is the pipeline.
interface result_pipe_ep_if #(
  parameter int REG_DATA_WD = 128,
  parameter int ADDR_WD     = 7
);
  logic                   iss_valid;
  logic [ADDR_WD-1:0]     iss_rt;
  logic [2:0]             iss_idx;
  logic                   flush;
  logic                   res2_valid;
  logic [REG_DATA_WD-1:0] res2_data;
  logic                   res3_valid;
  logic [REG_DATA_WD-1:0] res3_data;
  logic                   res6_valid;
  logic [REG_DATA_WD-1:0] res6_data;

  logic [ADDR_WD-1:0]     rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7;
  logic [2:0]             rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7;
  logic [REG_DATA_WD-1:0] rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7;
  logic                   rf_we_wb;
  logic [ADDR_WD-1:0]     rf_addr_wb;
  logic [REG_DATA_WD-1:0] rf_data_wb;
  logic                   err;

  modport master (
    output iss_valid, iss_rt, iss_idx, flush,
    output res2_valid, res2_data, res3_valid, res3_data, res6_valid, res6_data,
    input  rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7,
    input  rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7,
    input  rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7,
    input  rf_we_wb, rf_addr_wb, rf_data_wb, err
  );

  modport slave (
    input  iss_valid, iss_rt, iss_idx, flush,
    input  res2_valid, res2_data, res3_valid, res3_data, res6_valid, res6_data,
    output rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7,
    output rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7,
    output rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7,
    output rf_we_wb, rf_addr_wb, rf_data_wb, err
  );
endinterface

// File: rtl/result_pipe_ep.sv
// Even-pipe result staging: entries shift s1..s7 then wb each cycle, capturing unit results
// at their completion stage. Invalid entries are held all-zero so outputs come straight from flops.
module result_pipe_ep #(
  parameter int REG_DATA_WD  = 128,
  parameter int ADDR_WD      = 7,
  parameter int FLUSH_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  result_pipe_ep_if.slave bus
);
  localparam int NST = 8;  // s1..s7 plus wb at index 8
  localparam bit KILL_S2 = (FLUSH_STAGES >= 2);
  localparam bit KILL_S5 = (FLUSH_STAGES >= 5);

  logic                   valid_q [1:NST];
  logic                   valid_d [1:NST];
  logic [ADDR_WD-1:0]     addr_q  [1:NST];
  logic [ADDR_WD-1:0]     addr_d  [1:NST];
  logic [2:0]             idx_q   [1:NST];
  logic [2:0]             idx_d   [1:NST];
  logic [REG_DATA_WD-1:0] data_q  [1:NST];
  logic [REG_DATA_WD-1:0] data_d  [1:NST];
  logic                   err_q, err_d;

  logic                   cap_hit [2:NST];
  logic [REG_DATA_WD-1:0] cap_val [2:NST];
  logic                   m2, m3, m6, iss_ok, iss_bad;

  assign m2      = valid_q[1] && (idx_q[1] == 3'd1);
  assign m3      = valid_q[2] && ((idx_q[2] == 3'd2) || (idx_q[2] == 3'd4));
  assign m6      = valid_q[5] && (idx_q[5] == 3'd3);
  assign iss_ok  = bus.iss_valid && !bus.flush && (bus.iss_idx >= 3'd1) && (bus.iss_idx <= 3'd4);
  assign iss_bad = bus.iss_valid && (bus.iss_idx > 3'd4);

  always_comb begin
    for (int k = 2; k <= NST; k++) begin
      cap_hit[k] = 1'b0;
      cap_val[k] = '0;
    end
    cap_hit[2] = m2;
    cap_val[2] = bus.res2_valid ? bus.res2_data : '0;
    cap_hit[3] = m3;
    cap_val[3] = bus.res3_valid ? bus.res3_data : '0;
    cap_hit[6] = m6;
    cap_val[6] = bus.res6_valid ? bus.res6_data : '0;
  end

  // Missing results on flushed entries are not errors; orphan results always are.
  always_comb begin
    err_d = err_q | iss_bad
          | (bus.res2_valid && !m2) | (!bus.res2_valid && m2 && !bus.flush)
          | (bus.res3_valid && !m3) | (!bus.res3_valid && m3 && !(bus.flush && KILL_S2))
          | (bus.res6_valid && !m6) | (!bus.res6_valid && m6 && !(bus.flush && KILL_S5));
  end

  assign valid_d[1] = iss_ok;
  assign addr_d[1]  = iss_ok ? bus.iss_rt : '0;
  assign idx_d[1]   = iss_ok ? bus.iss_idx : 3'd0;
  assign data_d[1]  = '0;

  generate
    for (genvar gi = 2; gi <= NST; gi++) begin : g_stage
      localparam bit KILLABLE = ((gi - 1) <= FLUSH_STAGES);
      logic keep;
      assign keep        = valid_q[gi-1] && !(bus.flush && KILLABLE);
      assign valid_d[gi] = keep;
      assign addr_d[gi]  = keep ? addr_q[gi-1] : '0;
      assign idx_d[gi]   = keep ? idx_q[gi-1] : 3'd0;
      assign data_d[gi]  = !keep ? '0 : (cap_hit[gi] ? cap_val[gi] : data_q[gi-1]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= NST; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        idx_q[k]   <= 3'd0;
        data_q[k]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int k = 1; k <= NST; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
        idx_q[k]   <= idx_d[k];
        data_q[k]  <= data_d[k];
      end
      err_q <= err_d;
    end
  end

  assign bus.rf_addr_s2 = addr_q[2];
  assign bus.rf_addr_s3 = addr_q[3];
  assign bus.rf_addr_s4 = addr_q[4];
  assign bus.rf_addr_s5 = addr_q[5];
  assign bus.rf_addr_s6 = addr_q[6];
  assign bus.rf_addr_s7 = addr_q[7];
  assign bus.rf_idx_s2  = idx_q[2];
  assign bus.rf_idx_s3  = idx_q[3];
  assign bus.rf_idx_s4  = idx_q[4];
  assign bus.rf_idx_s5  = idx_q[5];
  assign bus.rf_idx_s6  = idx_q[6];
  assign bus.rf_idx_s7  = idx_q[7];
  assign bus.rf_data_s2 = data_q[2];
  assign bus.rf_data_s3 = data_q[3];
  assign bus.rf_data_s4 = data_q[4];
  assign bus.rf_data_s5 = data_q[5];
  assign bus.rf_data_s6 = data_q[6];
  assign bus.rf_data_s7 = data_q[7];
  assign bus.rf_we_wb   = valid_q[NST];
  assign bus.rf_addr_wb = addr_q[NST];
  assign bus.rf_data_wb = data_q[NST];
  assign bus.err        = err_q;
endmodule

// File: tb/tb_result_pipe_ep.sv
// Directed bench for result_pipe_ep: issue/result/flush/reset scenarios with hand-computed expectations.
module tb_result_pipe_ep;
  localparam int DW = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  result_pipe_ep_if #(.REG_DATA_WD(DW), .ADDR_WD(AW)) bus ();
  result_pipe_ep #(.REG_DATA_WD(DW), .ADDR_WD(AW), .FLUSH_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [DW-1:0] DA5 = {16{8'hA5}};
  localparam logic [DW-1:0] D1  = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [DW-1:0] D2  = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [DW-1:0] D3  = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [DW-1:0] D4  = 128'h4444_0000_0000_0000_0000_0000_0000_0004;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.iss_valid  = 1'b0;
    bus.iss_rt     = '0;
    bus.iss_idx    = 3'd0;
    bus.flush      = 1'b0;
    bus.res2_valid = 1'b0;
    bus.res2_data  = '0;
    bus.res3_valid = 1'b0;
    bus.res3_data  = '0;
    bus.res6_valid = 1'b0;
    bus.res6_data  = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rt, input logic [2:0] idx);
    bus.iss_valid = 1'b1;
    bus.iss_rt    = rt;
    bus.iss_idx   = idx;
    $display("issue rt=%0h idx=%0d at %0t", rt, idx, $time);
  endtask

  function automatic logic [2:0] st_idx(input int k);
    case (k)
      2: return bus.rf_idx_s2;
      3: return bus.rf_idx_s3;
      4: return bus.rf_idx_s4;
      5: return bus.rf_idx_s5;
      6: return bus.rf_idx_s6;
      default: return bus.rf_idx_s7;
    endcase
  endfunction

  function automatic logic [DW-1:0] st_data(input int k);
    case (k)
      2: return bus.rf_data_s2;
      3: return bus.rf_data_s3;
      4: return bus.rf_data_s4;
      5: return bus.rf_data_s5;
      6: return bus.rf_data_s6;
      default: return bus.rf_data_s7;
    endcase
  endfunction

  function automatic logic any_out();
    return |{bus.rf_addr_s2, bus.rf_addr_s3, bus.rf_addr_s4, bus.rf_addr_s5, bus.rf_addr_s6,
             bus.rf_addr_s7, bus.rf_idx_s2, bus.rf_idx_s3, bus.rf_idx_s4, bus.rf_idx_s5,
             bus.rf_idx_s6, bus.rf_idx_s7, bus.rf_data_s2, bus.rf_data_s3, bus.rf_data_s4,
             bus.rf_data_s5, bus.rf_data_s6, bus.rf_data_s7, bus.rf_we_wb, bus.rf_addr_wb,
             bus.rf_data_wb, bus.err};
  endfunction

  initial begin
    int we_seen;
    idle();
    rst = 1'b0;
    tickn(2);
    chk("reset_outs", DW'(any_out()), '0);
    rst = 1'b1;

    // single idx-1 issue
    issue(7'h05, 3'd1);
    tickn(1);
    idle();
    bus.res2_valid = 1'b1;
    bus.res2_data  = DA5;
    tickn(1);
    idle();
    chk("t1_s2_addr", DW'(bus.rf_addr_s2), 128'h5);
    chk("t1_s2_idx", DW'(bus.rf_idx_s2), 128'h1);
    chk("t1_s2_data", bus.rf_data_s2, DA5);
    tickn(6);
    chk("t1_wb_we", DW'(bus.rf_we_wb), 128'h1);
    chk("t1_wb_addr", DW'(bus.rf_addr_wb), 128'h5);
    chk("t1_wb_data", bus.rf_data_wb, DA5);
    chk("t1_err", DW'(bus.err), 128'h0);
    tickn(1);
    chk("t1_wb_done", DW'(bus.rf_we_wb), 128'h0);

    // idx-3 issue, late result on res6
    issue(7'h10, 3'd3);
    tickn(1);
    idle();
    for (int k = 2; k <= 5; k++) begin
      tickn(1);
      chk($sformatf("t2_s%0d_idx", k), DW'(st_idx(k)), 128'h3);
      chk($sformatf("t2_s%0d_data", k), st_data(k), '0);
    end
    bus.res6_valid = 1'b1;
    bus.res6_data  = 128'h1;
    tickn(1);
    idle();
    chk("t2_s6_data", bus.rf_data_s6, 128'h1);
    tickn(2);
    chk("t2_wb_we", DW'(bus.rf_we_wb), 128'h1);
    chk("t2_wb_addr", DW'(bus.rf_addr_wb), 128'h10);
    chk("t2_wb_data", bus.rf_data_wb, 128'h1);
    chk("t2_err", DW'(bus.err), 128'h0);
    tickn(1);

    // back-to-back idx 1, 2, 4
    issue(7'h01, 3'd1);
    tickn(1);
    idle();
    issue(7'h02, 3'd2);
    bus.res2_valid = 1'b1;
    bus.res2_data  = D1;
    tickn(1);
    idle();
    issue(7'h03, 3'd4);
    tickn(1);
    idle();
    bus.res3_valid = 1'b1;
    bus.res3_data  = D2;
    tickn(1);
    idle();
    bus.res3_valid = 1'b1;
    bus.res3_data  = D3;
    tickn(1);
    idle();
    tickn(3);
    chk("t3_wb0_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h01});
    chk("t3_wb0_data", bus.rf_data_wb, D1);
    tickn(1);
    chk("t3_wb1_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h02});
    chk("t3_wb1_data", bus.rf_data_wb, D2);
    tickn(1);
    chk("t3_wb2_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h03});
    chk("t3_wb2_data", bus.rf_data_wb, D3);
    chk("t3_err", DW'(bus.err), 128'h0);
    tickn(1);

    // flush at T+4 with FLUSH_STAGES = 2
    issue(7'h21, 3'd1);
    tickn(1);
    idle();
    issue(7'h22, 3'd1);
    bus.res2_valid = 1'b1; bus.res2_data = D1;
    tickn(1);
    idle();
    issue(7'h23, 3'd1);
    bus.res2_valid = 1'b1; bus.res2_data = D2;
    tickn(1);
    idle();
    issue(7'h24, 3'd1);
    bus.res2_valid = 1'b1; bus.res2_data = D3;
    tickn(1);
    idle();
    issue(7'h25, 3'd1);
    bus.flush = 1'b1;
    bus.res2_valid = 1'b1; bus.res2_data = D4;
    tickn(1);
    idle();
    chk("t4_s2_idx", DW'(bus.rf_idx_s2), 128'h0);
    chk("t4_s3_addr", DW'(bus.rf_addr_s3), 128'h0);
    chk("t4_s4_addr", DW'(bus.rf_addr_s4), 128'h22);
    tickn(3);
    chk("t4_wb0_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h21});
    chk("t4_wb0_data", bus.rf_data_wb, D1);
    tickn(1);
    chk("t4_wb1_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h22});
    chk("t4_wb1_data", bus.rf_data_wb, D2);
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tickn(1);
      if (bus.rf_we_wb) we_seen++;
    end
    chk("t4_no_wb", DW'(we_seen), 128'h0);
    chk("t4_err", DW'(bus.err), 128'h0);

    // protocol errors: orphan res3, then idx-1 with no res2
    bus.res3_valid = 1'b1;
    bus.res3_data  = D4;
    tickn(1);
    idle();
    chk("t5_err_set", DW'(bus.err), 128'h1);
    issue(7'h09, 3'd1);
    tickn(1);
    idle();
    tickn(7);
    chk("t5_wb_addr", DW'({bus.rf_we_wb, bus.rf_addr_wb}), {120'h0, 1'b1, 7'h09});
    chk("t5_wb_data", bus.rf_data_wb, '0);
    chk("t5_err_held", DW'(bus.err), 128'h1);
    tickn(1);

    // reset with five entries in flight
    for (int i = 0; i < 5; i++) begin
      issue(AW'(7'h30 + i), 3'd1);
      if (i > 0) begin
        bus.res2_valid = 1'b1;
        bus.res2_data  = D1;
      end
      tickn(1);
      idle();
    end
    rst = 1'b0;
    tickn(1);
    rst = 1'b1;
    chk("t6_outs_zero", DW'(any_out()), '0);
    chk("t6_err", DW'(bus.err), 128'h0);
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tickn(1);
      if (bus.rf_we_wb) we_seen++;
    end
    chk("t6_no_wb", DW'(we_seen), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
